// File: rtl/csr_pkg.sv
// Shared CSR types, addresses, write masks and the packed view of all machine-mode CSRs.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } csr_op_t;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MIE      = 12'h304;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam csr_addr_t CSR_MIP      = 12'h344;
  localparam csr_addr_t CSR_SATP     = 12'h180;
  localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
  localparam csr_addr_t CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MSTATUS_MPP  = 11;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MIP_WMASK     = 64'h0;
  localparam logic [63:0] ALIGN4_WMASK  = ~64'h3;

  typedef struct packed {
    logic [63:0] mstatus;
    logic [63:0] mie;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mip;
    logic [63:0] mcycle;
    logic [63:0] satp;
    logic [63:0] mhartid;
  } csr_pack;

  // Address space 0xC00-0xFFF is read-only by encoding.
  function automatic logic csr_read_only(input csr_addr_t addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_file_wdata_alu.sv
// CSR read-modify-write and per-CSR write-mask merge, with the mstatus.MPP WARL fix-up.
module csr_wdata_alu
  import csr_pkg::*;
(
  input  csr_op_t     op,
  input  logic [63:0] old,
  input  logic [63:0] src,
  input  logic [63:0] mask,
  input  logic        warl_mpp,
  output logic [63:0] wdata
);

  logic [63:0] rmw;
  logic [63:0] merged;

  always_comb begin
    rmw = old;
    unique case (op)
      CSR_RW:  rmw = src;
      CSR_RS:  rmw = old | src;
      CSR_RC:  rmw = old & ~src;
      default: rmw = old;
    endcase

    merged = (old & ~mask) | (rmw & mask);
    // MPP only holds M (11) or U (00); other encodings keep the previous mode.
    if (warl_mpp && (merged[MSTATUS_MPP +: 2] == 2'b01 || merged[MSTATUS_MPP +: 2] == 2'b10))
      merged[MSTATUS_MPP +: 2] = old[MSTATUS_MPP +: 2];
    wdata = merged;
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage, write path, mcycle counter, trap entry and mret updates.
// Optional feature macro: CSR_TRAP_EN enables trap/mret state updates.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [63:0] HART_ID = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  csr_op_t     wr_op,
  input  logic [11:0] wr_addr,
  input  logic [63:0] wr_src,
  output logic        wr_illegal,
  input  logic        trap_valid,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  output logic [63:0] trap_target,
  output logic [63:0] mret_target,
  output csr_pack     csr
);

  csr_pack     q;
  csr_pack     d;
  logic [63:0] old;
  logic [63:0] mask;
  logic        warl_mpp;
  logic        hit;
  logic        read_only;
  logic        no_write;
  logic        we;
  logic [63:0] wdata;

  always_comb begin
    old      = '0;
    mask     = '0;
    warl_mpp = 1'b0;
    hit      = 1'b1;
    unique case (wr_addr)
      CSR_MSTATUS:  begin old = q.mstatus;  mask = MSTATUS_WMASK; warl_mpp = 1'b1; end
      CSR_MIE:      begin old = q.mie;      mask = '1; end
      CSR_MTVEC:    begin old = q.mtvec;    mask = ALIGN4_WMASK; end
      CSR_MSCRATCH: begin old = q.mscratch; mask = '1; end
      CSR_MEPC:     begin old = q.mepc;     mask = ALIGN4_WMASK; end
      CSR_MCAUSE:   begin old = q.mcause;   mask = '1; end
      CSR_MTVAL:    begin old = q.mtval;    mask = '1; end
      CSR_MIP:      begin old = q.mip;      mask = MIP_WMASK; end
      CSR_SATP:     begin old = q.satp;     mask = '1; end
      CSR_MCYCLE:   begin old = q.mcycle;   mask = '1; end
      CSR_MHARTID:  begin old = q.mhartid;  mask = '0; end
      default:      hit = 1'b0;
    endcase
  end

  // Set/clear with a zero source is a pure read, so it is legal even on read-only CSRs.
  assign read_only  = csr_read_only(wr_addr);
  assign no_write   = (wr_op != CSR_RW) && (wr_src == '0);
  assign wr_illegal = wr_valid && (!hit || (read_only && !no_write));
  assign we         = wr_valid && hit && !read_only && !no_write;

  csr_wdata_alu u_wdata_alu (
    .op       (wr_op),
    .old      (old),
    .src      (wr_src),
    .mask     (mask),
    .warl_mpp (warl_mpp),
    .wdata    (wdata)
  );

  always_comb begin
    d        = q;
    d.mcycle = q.mcycle + 64'd1;
`ifdef CSR_TRAP_EN
    if (trap_valid) begin
      d.mepc                  = trap_pc & ~64'h3;
      d.mcause                = trap_cause;
      d.mtval                 = trap_tval;
      d.mstatus[MSTATUS_MPIE] = q.mstatus[MSTATUS_MIE];
      d.mstatus[MSTATUS_MIE]  = 1'b0;
      d.mstatus[MSTATUS_MPP +: 2] = 2'b11;
    end else if (mret_valid) begin
      d.mstatus[MSTATUS_MIE]  = q.mstatus[MSTATUS_MPIE];
      d.mstatus[MSTATUS_MPIE] = 1'b1;
      d.mstatus[MSTATUS_MPP +: 2] = 2'b00;
    end else if (we) begin
`else
    if (we) begin
`endif
      unique case (wr_addr)
        CSR_MSTATUS:  d.mstatus  = wdata;
        CSR_MIE:      d.mie      = wdata;
        CSR_MTVEC:    d.mtvec    = wdata;
        CSR_MSCRATCH: d.mscratch = wdata;
        CSR_MEPC:     d.mepc     = wdata;
        CSR_MCAUSE:   d.mcause   = wdata;
        CSR_MTVAL:    d.mtval    = wdata;
        CSR_MIP:      d.mip      = wdata;
        CSR_SATP:     d.satp     = wdata;
        CSR_MCYCLE:   d.mcycle   = wdata;
        default:      ;
      endcase
    end
  end

`ifndef CSR_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^{trap_valid, trap_cause, trap_pc, trap_tval, mret_valid};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= '0;
      q.mhartid <= HART_ID;
    end else begin
      q <= d;
    end
  end

  assign csr         = q;
  assign trap_target = {q.mtvec[63:2], 2'b00};
  assign mret_target = q.mepc;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: expectations queued at stimulus time, compared one cycle later.
module tb_csr_file;
  import csr_pkg::*;

  localparam logic [63:0] HART = 64'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  csr_op_t     wr_op;
  logic [11:0] wr_addr;
  logic [63:0] wr_src;
  logic        wr_illegal;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic [63:0] trap_pc;
  logic [63:0] trap_tval;
  logic        mret_valid;
  logic [63:0] trap_target;
  logic [63:0] mret_target;
  csr_pack     csr;

  int n_checks = 0;
  int n_errors = 0;

  string       q_tag[$];
  int          q_sel[$];
  logic [63:0] q_val[$];

  csr_file #(.HART_ID(HART)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_op       (wr_op),
    .wr_addr     (wr_addr),
    .wr_src      (wr_src),
    .wr_illegal  (wr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret_valid  (mret_valid),
    .trap_target (trap_target),
    .mret_target (mret_target),
    .csr         (csr)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] field(input int sel);
    case (sel)
      0:  return csr.mstatus;
      1:  return csr.mie;
      2:  return csr.mtvec;
      3:  return csr.mscratch;
      4:  return csr.mepc;
      5:  return csr.mcause;
      6:  return csr.mtval;
      7:  return csr.mip;
      8:  return csr.mcycle;
      9:  return csr.satp;
      10: return csr.mhartid;
      11: return trap_target;
      12: return mret_target;
      default: return 64'hx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_next(input string tag, input int sel, input logic [63:0] val);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_val.push_back(val);
  endtask

  task automatic idle();
    wr_valid   = 1'b0;
    wr_op      = CSR_RW;
    wr_addr    = '0;
    wr_src     = '0;
    trap_valid = 1'b0;
    trap_cause = '0;
    trap_pc    = '0;
    trap_tval  = '0;
    mret_valid = 1'b0;
  endtask

  task automatic write(input csr_op_t op, input logic [11:0] addr, input logic [63:0] src);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_addr  = addr;
    wr_src   = src;
  endtask

  // One clock: results of the request just driven are compared #1 after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    while (q_sel.size() > 0) begin
      int          sel;
      string       tag;
      logic [63:0] val;
      sel = q_sel.pop_front();
      tag = q_tag.pop_front();
      val = q_val.pop_front();
      check(tag, field(sel), val);
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp_mstatus;
    logic [63:0] exp_mepc;

    idle();
    reset = 1'b1;
    #1;
    check("rst_mstatus", csr.mstatus, 64'h0);
    check("rst_mcycle", csr.mcycle, 64'h0);
    check("rst_mhartid", csr.mhartid, HART);
    check("rst_trap_target", trap_target, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) cycle();
    expect_next("idle_mcycle", 8, 64'd10);
    expect_next("idle_mhartid", 10, HART);
    expect_next("idle_mscratch", 3, 64'h0);
    expect_next("idle_mepc", 4, 64'h0);
    cycle();

    write(CSR_RW, CSR_MSCRATCH, 64'hdead_beef);
    expect_next("rw_mscratch", 3, 64'hdead_beef);
    cycle();
    write(CSR_RS, CSR_MSCRATCH, 64'hf0);
    expect_next("rs_mscratch", 3, 64'hdead_beff);
    cycle();
    write(CSR_RC, CSR_MSCRATCH, 64'h0f);
    expect_next("rc_mscratch", 3, 64'hdead_bef0);
    cycle();

    write(CSR_RW, CSR_MTVEC, 64'h8000_0003);
    #1 check("mtvec_legal", {63'd0, wr_illegal}, 64'd0);
    expect_next("mtvec", 2, 64'h8000_0000);
    expect_next("trap_target", 11, 64'h8000_0000);
    cycle();

    write(CSR_RW, CSR_MHARTID, 64'd5);
    #1 check("mhartid_illegal", {63'd0, wr_illegal}, 64'd1);
    expect_next("mhartid_kept", 10, HART);
    cycle();
    write(CSR_RS, CSR_MHARTID, 64'd0);
    #1 check("mhartid_rs0_legal", {63'd0, wr_illegal}, 64'd0);
    cycle();
    write(CSR_RW, 12'h7C0, 64'd1);
    #1 check("unimpl_illegal", {63'd0, wr_illegal}, 64'd1);
    expect_next("unimpl_mscratch", 3, 64'hdead_bef0);
    cycle();

    write(CSR_RW, CSR_MIP, '1);
    expect_next("mip_masked", 7, 64'h0);
    cycle();
    write(CSR_RW, CSR_MSTATUS, '1);
    expect_next("mstatus_mask", 0, 64'h1888);
    cycle();
    write(CSR_RW, CSR_MSTATUS, 64'h0800);
    expect_next("mstatus_mpp_warl", 0, 64'h1800);
    cycle();
    write(CSR_RW, CSR_MSTATUS, 64'h0008);
    expect_next("mstatus_mie", 0, 64'h0008);
    cycle();

    write(CSR_RW, CSR_MEPC, 64'h1237);
    expect_next("mepc_align", 4, 64'h1234);
    expect_next("mret_target", 12, 64'h1234);
    cycle();

    trap_valid = 1'b1;
    trap_pc    = 64'h1002;
    trap_cause = 64'd11;
    trap_tval  = 64'h42;
`ifdef CSR_TRAP_EN
    exp_mstatus = 64'h1880;
    exp_mepc    = 64'h1000;
    expect_next("trap_mcause", 5, 64'd11);
    expect_next("trap_mtval", 6, 64'h42);
`else
    exp_mstatus = 64'h0008;
    exp_mepc    = 64'h1234;
    expect_next("trap_mcause", 5, 64'd0);
`endif
    expect_next("trap_mstatus", 0, exp_mstatus);
    expect_next("trap_mepc", 4, exp_mepc);
    cycle();

    mret_valid = 1'b1;
`ifdef CSR_TRAP_EN
    expect_next("mret_mstatus", 0, 64'h0088);
`else
    expect_next("mret_mstatus", 0, 64'h0008);
`endif
    cycle();

    trap_valid = 1'b1;
    trap_pc    = 64'h3006;
    write(CSR_RW, CSR_MEPC, 64'h2000);
`ifdef CSR_TRAP_EN
    expect_next("trap_over_wr", 4, 64'h3004);
`else
    expect_next("trap_over_wr", 4, 64'h2000);
`endif
    cycle();

    write(CSR_RW, CSR_MCYCLE, '1);
    expect_next("mcycle_load", 8, 64'hffff_ffff_ffff_ffff);
    cycle();
    expect_next("mcycle_wrap", 8, 64'h0);
    cycle();

    write(CSR_RW, CSR_MSCRATCH, 64'h55);
    #2 reset = 1'b1;
    #1;
    check("async_mscratch", csr.mscratch, 64'h0);
    check("async_mstatus", csr.mstatus, 64'h0);
    check("async_mtvec", csr.mtvec, 64'h0);
    check("async_mhartid", csr.mhartid, HART);
    check("async_trap_target", trap_target, 64'h0);
    check("async_mret_target", mret_target, 64'h0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    expect_next("post_rst_mscratch", 3, 64'h0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Architectural machine-mode CSR storage and write path: the counterpart of the CSR read selector. Holds every implemented CSR as state and presents the full `csr_pack` to the read side each cycle. Accepts CSR-instruction writes from the writeback stage and applies read-modify-write and WARL masking. Advances `mcycle` and commits trap entry and `mret` state updates.

## Interface

Parameters:
- `HART_ID`, default 0: reset and constant value of `mhartid`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: one-cycle CSR write request.
- `wr_op` in `csr_op_t`: `CSR_RW`, `CSR_RS`, `CSR_RC`. Immediate forms arrive already mapped, with `wr_src` zero-extended.
- `wr_addr` in 12 (`csr_addr`): target CSR.
- `wr_src` in 64: rs1 value or zero-extended uimm.
- `wr_illegal` out 1: combinational. High when `wr_valid` targets an unimplemented or read-only CSR.
- `trap_valid` in 1: commit trap entry this cycle.
- `trap_cause` in 64: `mcause` value.
- `trap_pc` in 64: `mepc` value.
- `trap_tval` in 64: `mtval` value.
- `mret_valid` in 1: commit `mret` this cycle.
- `trap_target` out 64: combinational, `{mtvec[63:2], 2'b00}`.
- `mret_target` out 64: combinational, current `mepc`.
- `csr` out `csr_pack`: registered value of all CSRs.

## Operation

- Read-modify-write:
  - `CSR_RW`: new value = `src`.
  - `CSR_RS`: new value = `old | src`.
  - `CSR_RC`: new value = `old & ~src`.
  - `old` is the current register value, not the masked view.
- `CSR_RS` or `CSR_RC` with `wr_src == 0` performs no write and never raises `wr_illegal` for read-only CSRs.
- Stored value = `(old & ~MASK) | (new & MASK)`, using the per-CSR write mask.
  - `mstatus`: mask `MSTATUS_WMASK`. Bits MIE(3), MPIE(7) and MPP(12:11) are writable. MPP accepts only `2'b00` and `2'b11`; any other value leaves MPP unchanged.
  - `mtvec`: bits 1:0 are forced to `2'b00` (direct mode only).
  - `mepc`: bits 1:0 are forced to 0.
  - `mip`: mask `MIP_WMASK` (zero).
  - `mie`, `mscratch`, `mcause`, `mtval`, `mcycle`, `satp`: fully writable.
  - `mhartid`: read-only.
- Priority within one cycle, highest first: `trap_valid`, then `mret_valid`, then `wr_valid`. A lower-priority request is dropped, not queued.
- Trap entry:
  - `mepc <= trap_pc & ~3`
  - `mcause <= trap_cause`
  - `mtval <= trap_tval`
  - `mstatus.MPIE <= MIE`, `MIE <= 0`, `MPP <= 2'b11`
- `mret`: `MIE <= MPIE`, `MPIE <= 1`, `MPP <= 2'b00`.
- `mcycle` increments by 1 every cycle and wraps from `2^64-1` to 0. An accepted write to `mcycle` loads the written value instead, with no increment that cycle.
- A write to an illegal address changes no state.

## Timing

- Writes, trap and `mret` updates appear on `csr` on the cycle after the request (latency 1). A read in the same cycle as a write returns the old value; the pipeline forwards if needed.
- `wr_illegal`, `trap_target` and `mret_target` are combinational, with zero latency.
- No back-pressure: every request is accepted in the cycle it is presented.
- Reset, asynchronous and valid at any point including mid-sequence:
  - all CSRs become 0, except `mhartid = HART_ID`
  - `trap_target` and `mret_target` become 0
  - `wr_illegal` follows its inputs
  - `mcycle` restarts at 0 on the first edge after `reset` deasserts

## Configuration

- `CSR_TRAP_EN` defined: trap and `mret` ports and logic are present as described.
- `CSR_TRAP_EN` undefined:
  - the trap and `mret` inputs are ignored
  - `mepc`, `mcause`, `mtval` and `mstatus` change only via CSR writes
  - `trap_target` and `mret_target` still reflect `mtvec` and `mepc`

## Structure

- Add to `csr_pkg`:
  - `csr_op_t`
  - `MSTATUS_WMASK`, `MIP_WMASK`
  - `MSTATUS_MIE`, `MSTATUS_MPIE`, `MSTATUS_MPP` bit-position constants
- One sub-module, `csr_wdata_alu`: combinational RW/RS/RC plus mask merge, instantiated once.
- Read-side decode stays in the existing selector; this block only supplies `csr`.

## Test plan

- Reset, then 10 idle cycles -> `mcycle` = 10, `mhartid` = `HART_ID`, all other CSRs 0.
- `CSR_RW mscratch 0xdead_beef`, then `CSR_RS 0xF0`, then `CSR_RC 0x0F` -> `mscratch` reads `0xdead_beef`, `0xdead_beff`, `0xdead_bef0` on successive cycles.
- `CSR_RW mtvec 0x8000_0003` -> `mtvec` = `0x8000_0000`, `trap_target` = `0x8000_0000`. `CSR_RW mhartid 5` -> `wr_illegal` = 1, `mhartid` unchanged.
- With MIE = 1, assert `trap_valid` with pc `0x1002`, cause 11, tval `0x42` -> `mepc` = `0x1000`, `mcause` = 11, MIE = 0, MPIE = 1, MPP = 3. Next, `mret_valid` -> MIE = 1, MPIE = 1, MPP = 0.
- Same cycle: `trap_valid` and `wr_valid` to `mepc` -> trap value wins. Write `mcycle` = `2^64-1` -> next cycle 0 (wrap after load).
- Assert `reset` mid-sequence, asynchronously between edges -> all outputs reach reset values immediately, without waiting for a clock edge.
